// File: rtl/three_ones_pattern_tx_if.sv
// Parallel request / serial stimulus bundle between the harness and the
// three-ones pattern transmitter.
interface three_ones_pattern_tx_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 5
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic             z_exp;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output start, pattern, len,
    input  x, x_valid, busy, done, z_exp, hit_cnt
  );

  modport slave (
    input  start, pattern, len,
    output x, x_valid, busy, done, z_exp, hit_cnt
  );
endinterface

// File: rtl/three_ones_pattern_tx.sv
// Shifts a pattern out MSB-first on x and predicts the overlapping Mealy
// three-consecutive-1s detector output (z_exp) plus a per-frame hit count.
module three_ones_pattern_tx #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  three_ones_pattern_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {D0, D1, D2} model_t;

  state_t           state, state_nxt;
  model_t           model, model_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [LEN_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] hit, hit_nxt;
  logic [LEN_W-1:0] len_c;
  logic             x_bit;
  logic             z_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      model <= D0;
      sreg  <= '0;
      cnt   <= '0;
      hit   <= '0;
    end else begin
      state <= state_nxt;
      model <= model_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      hit   <= hit_nxt;
    end
  end

  always_comb begin
    len_c       = (bus.len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.len;
    x_bit       = (state == SHIFT) && sreg[WIDTH-1];
    z_bit       = x_bit && (model == D2);

    state_nxt   = state;
    model_nxt   = model;
    sreg_nxt    = sreg;
    cnt_nxt     = cnt;
    hit_nxt     = hit;

    bus.x       = x_bit;
    bus.x_valid = (state == SHIFT);
    bus.busy    = (state != IDLE);
    bus.done    = (state == DONE);
    bus.z_exp   = z_bit;
    bus.hit_cnt = hit;

    case (state)
      IDLE: begin
        if (bus.start) begin
          hit_nxt = '0;
          if (len_c != '0) begin
            sreg_nxt  = bus.pattern;
            cnt_nxt   = len_c;
            model_nxt = D0;
            state_nxt = SHIFT;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
        cnt_nxt  = cnt - LEN_W'(1);
        if (x_bit) begin
          model_nxt = (model == D0) ? D1 : D2;
        end else begin
          model_nxt = D0;
        end
        if (z_bit && (hit != '1)) begin
          hit_nxt = hit + CNT_W'(1);
        end
        if (cnt == LEN_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Frames are independent: no trailing-1 history carries over.
        model_nxt = D0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_three_ones_pattern_tx.sv
// Directed plus randomized frames checked cycle-by-cycle against a
// bit-list model of the serial stream and its three-ones detections.
module tb_three_ones_pattern_tx;

  localparam int WIDTH = 16;
  localparam int LEN_W = 5;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  three_ones_pattern_tx_if #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  three_ones_pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".x"},       32'(bus.x),       0);
    chk({tag, ".x_valid"}, 32'(bus.x_valid), 0);
    chk({tag, ".z_exp"},   32'(bus.z_exp),   0);
  endtask

  // inj: bit index during which a competing start is pulsed (0 = none)
  // abort_at: bit index during which reset is asserted (0 = none)
  task automatic frame(input logic [15:0] pat, input int unsigned ln,
                       input int unsigned inj, input int unsigned abort_at);
    int unsigned L;
    int unsigned hits;
    logic        bits[$];
    logic        zb;
    L = (ln > WIDTH) ? WIDTH : ln;
    for (int unsigned i = 0; i < L; i++) bits.push_back(pat[WIDTH-1-i]);

    @(negedge clk);
    bus.start   = 1'b1;
    bus.pattern = pat;
    bus.len     = LEN_W'(ln);
    @(posedge clk);
    #1 bus.start = 1'b0;
    hits = 0;

    for (int unsigned i = 1; i <= L; i++) begin
      zb = (i >= 3) && bits[i-1] && bits[i-2] && bits[i-3];
      chk("bit.x",       32'(bus.x),       32'(bits[i-1]));
      chk("bit.x_valid", 32'(bus.x_valid), 1);
      chk("bit.busy",    32'(bus.busy),    1);
      chk("bit.done",    32'(bus.done),    0);
      chk("bit.z_exp",   32'(bus.z_exp),   32'(zb));
      chk("bit.hit_cnt", 32'(bus.hit_cnt), hits);
      if (i == abort_at) begin
        #2 rst = 1'b0;
        #1;
        chk_quiet("abort");
        chk("abort.busy",    32'(bus.busy),    0);
        chk("abort.done",    32'(bus.done),    0);
        chk("abort.hit_cnt", 32'(bus.hit_cnt), 0);
        @(posedge clk);
        #1 chk("abort.done_held", 32'(bus.done), 0);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (i == inj) begin
        bus.start   = 1'b1;
        bus.pattern = 16'($urandom);
        bus.len     = LEN_W'($urandom);
      end
      if (zb && hits < (1 << CNT_W) - 1) hits++;
      @(posedge clk);
      #1 bus.start = 1'b0;
    end

    chk_quiet("done");
    chk("done.done",    32'(bus.done),    1);
    chk("done.busy",    32'(bus.busy),    1);
    chk("done.hit_cnt", 32'(bus.hit_cnt), hits);
    @(posedge clk);
    #1;
    chk_quiet("idle");
    chk("idle.done",    32'(bus.done),    0);
    chk("idle.busy",    32'(bus.busy),    0);
    chk("idle.hit_cnt", 32'(bus.hit_cnt), hits);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.pattern = '0;
    bus.len     = '0;

    #12;
    chk_quiet("reset");
    chk("reset.busy",    32'(bus.busy),    0);
    chk("reset.done",    32'(bus.done),    0);
    chk("reset.hit_cnt", 32'(bus.hit_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    frame(16'h9E70, 13, 0, 0);
    frame(16'hFFFF, 16, 0, 0);
    frame(16'hFFFF, 0,  0, 0);
    frame(16'hFFFF, 20, 0, 0);
    frame(16'h9E70, 13, 4, 0);
    frame(16'hFFFF, 13, 0, 5);
    frame(16'hE000, 3,  0, 0);
    frame(16'hC000, 2,  0, 0);
    frame(16'h8000, 1,  0, 0);

    for (int unsigned n = 0; n < 30; n++) begin
      logic [15:0] p;
      int unsigned l;
      int unsigned ij;
      int unsigned ab;
      p  = 16'($urandom);
      l  = $urandom_range(0, 31);
      ij = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 16) : 0;
      ab = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 16) : 0;
      frame(p, l, ij, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
